// File: rtl/huff_tree_ctrl_if.sv
// Bundles the weight-load strobe and the code-stream outputs of huff_tree_ctrl.
// The total_bits signal exists only when HUFF_TOTAL_BITS_EN is defined.
interface huff_tree_ctrl_if #(
   parameter int WW = 5,
   parameter int CW = 7
);
   logic          in_valid;
   logic [WW-1:0] in_weight;
   logic          busy;
   logic          out_valid;
   logic [2:0]    out_char;
   logic [2:0]    out_len;
   logic [CW-1:0] out_code;
`ifdef HUFF_TOTAL_BITS_EN
   logic [10:0]   total_bits;

   modport master (output in_valid, in_weight,
                   input  busy, out_valid, out_char, out_len, out_code, total_bits);
   modport slave  (input  in_valid, in_weight,
                   output busy, out_valid, out_char, out_len, out_code, total_bits);
`else
   modport master (output in_valid, in_weight,
                   input  busy, out_valid, out_char, out_len, out_code);
   modport slave  (input  in_valid, in_weight,
                   output busy, out_valid, out_char, out_len, out_code);
`endif
endinterface

// File: rtl/huff_tree_ctrl.sv
// Builds an 8-symbol Huffman code: serial weight load, 7 single-cycle merges, 8 output beats.
// Optional macro HUFF_TOTAL_BITS_EN adds the total_bits output (sum of weight*length).
module huff_tree_ctrl #(
   parameter int NCHAR = 8,
   parameter int WW    = 5,
   parameter int CW    = 7
) (
   input logic             clk,
   input logic             rst_n,
   huff_tree_ctrl_if.slave bus
);
   localparam int NNODE = 2*NCHAR-1;
   localparam int KW    = WW+4;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MERGE, S_OUT} state_t;

   state_t           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [WW-1:0]    wt_q [NNODE];
   logic [WW-1:0]    wt_d [NNODE];
   logic [NNODE-1:0] act_q, act_d;
   logic [NCHAR-1:0] mask_q [NNODE];
   logic [NCHAR-1:0] mask_d [NNODE];
   logic [2:0]       len_q [NCHAR];
   logic [2:0]       len_d [NCHAR];
   logic [CW-1:0]    code_q [NCHAR];
   logic [CW-1:0]    code_d [NCHAR];

   logic [KW-1:0]    key1, key2;
   logic [3:0]       node_a, node_b, new_id;
   logic [NCHAR-1:0] mask_ab;

   function automatic logic [WW-1:0] sat_add(input logic [WW-1:0] a, input logic [WW-1:0] b);
      logic [WW:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[WW] ? {WW{1'b1}} : s[WW-1:0];
   endfunction

   // Inactive slots read as weight 31 / index 15, exactly like an unused sorter lane.
   function automatic logic [KW-1:0] node_key(input logic act, input logic [WW-1:0] w,
                                              input logic [3:0] id);
      return act ? {w, id} : {KW{1'b1}};
   endfunction

   always_comb begin
      key1 = {KW{1'b1}};
      key2 = {KW{1'b1}};
      for (int i = 0; i < NNODE; i++) begin
         if (node_key(act_q[i], wt_q[i], 4'(i)) < key1) begin
            key2 = key1;
            key1 = node_key(act_q[i], wt_q[i], 4'(i));
         end else if (node_key(act_q[i], wt_q[i], 4'(i)) < key2) begin
            key2 = node_key(act_q[i], wt_q[i], 4'(i));
         end
      end
   end

   assign node_a  = key1[3:0];
   assign node_b  = key2[3:0];
   assign new_id  = 4'(NCHAR) + {1'b0, cnt_q};
   assign mask_ab = mask_q[node_a] | mask_q[node_b];

`ifdef HUFF_TOTAL_BITS_EN
   logic [10:0] acc_q, acc_d, prod;
   assign prod = 11'(wt_q[cnt_q]) * 11'(len_q[cnt_q]);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         act_q   <= '0;
         for (int i = 0; i < NNODE; i++) begin
            wt_q[i]   <= '0;
            mask_q[i] <= '0;
         end
         for (int c = 0; c < NCHAR; c++) begin
            len_q[c]  <= '0;
            code_q[c] <= '0;
         end
`ifdef HUFF_TOTAL_BITS_EN
         acc_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         wt_q    <= wt_d;
         mask_q  <= mask_d;
         len_q   <= len_d;
         code_q  <= code_d;
`ifdef HUFF_TOTAL_BITS_EN
         acc_q   <= acc_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      wt_d    = wt_q;
      mask_d  = mask_q;
      len_d   = len_q;
      code_d  = code_q;
`ifdef HUFF_TOTAL_BITS_EN
      acc_d   = acc_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               state_d = S_LOAD;
               cnt_d   = 3'd1;
               wt_d[0] = bus.in_weight;
               for (int i = 0; i < NNODE; i++) begin
                  act_d[i]  = (i < NCHAR);
                  mask_d[i] = (i < NCHAR) ? NCHAR'(1) << i : '0;
               end
               for (int c = 0; c < NCHAR; c++) begin
                  len_d[c]  = '0;
                  code_d[c] = '0;
               end
`ifdef HUFF_TOTAL_BITS_EN
               acc_d   = '0;
`endif
            end
         end
         S_LOAD: begin
            if (!bus.in_valid) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               wt_d[cnt_q] = bus.in_weight;
               cnt_d       = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = S_MERGE;
            end
         end
         S_MERGE: begin
            // Leaves under A take bit 0, leaves under B bit 1, at their current depth.
            for (int c = 0; c < NCHAR; c++) begin
               if (mask_ab[c]) begin
                  code_d[c] = code_q[c] | (CW'(mask_q[node_b][c]) << len_q[c]);
                  len_d[c]  = len_q[c] + 3'd1;
               end
            end
            act_d[node_a]  = 1'b0;
            act_d[node_b]  = 1'b0;
            act_d[new_id]  = 1'b1;
            wt_d[new_id]   = sat_add(wt_q[node_a], wt_q[node_b]);
            mask_d[new_id] = mask_ab;
            cnt_d          = cnt_q + 3'd1;
            if (cnt_q == 3'd6) begin
               state_d = S_OUT;
               cnt_d   = '0;
            end
         end
         S_OUT: begin
            cnt_d = cnt_q + 3'd1;
`ifdef HUFF_TOTAL_BITS_EN
            acc_d = acc_q + prod;
`endif
            if (cnt_q == 3'd7) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.busy      = (state_q != S_IDLE) || bus.in_valid;
      bus.out_valid = 1'b0;
      bus.out_char  = '0;
      bus.out_len   = '0;
      bus.out_code  = '0;
`ifdef HUFF_TOTAL_BITS_EN
      bus.total_bits = '0;
`endif
      if (state_q == S_OUT) begin
         bus.out_valid = 1'b1;
         bus.out_char  = cnt_q;
         bus.out_len   = len_q[cnt_q];
         bus.out_code  = code_q[cnt_q];
`ifdef HUFF_TOTAL_BITS_EN
         if (cnt_q == 3'd7) bus.total_bits = acc_q + prod;
`endif
      end
   end

endmodule

// File: tb/tb_huff_tree_ctrl.sv
// Scoreboard bench for huff_tree_ctrl: a driver loads jobs and queues expected beats from a
// group-pointer Huffman model; a negedge monitor pops and compares every output cycle.
module tb_huff_tree_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   huff_tree_ctrl_if bus();
   huff_tree_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      int cyc;
      int ch;
      int ln;
      int cd;
      int tot;
   } exp_t;

   exp_t       expq[$];
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   int         last_t = 0;
   logic [4:0] wbuf [8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Reference: each leaf points at the tree node that currently contains it.
   task automatic model_push(input int t);
      int nwt[15];
      bit alive[15];
      int grp[8];
      int ln[8];
      int cd[8];
      int a, b, tot;
      exp_t e;
      for (int i = 0; i < 15; i++) begin
         nwt[i]   = (i < 8) ? int'(wbuf[i]) : 0;
         alive[i] = (i < 8);
      end
      for (int c = 0; c < 8; c++) begin
         grp[c] = c;
         ln[c]  = 0;
         cd[c]  = 0;
      end
      for (int r = 0; r < 7; r++) begin
         a = -1;
         b = -1;
         for (int i = 0; i < 15; i++) begin
            if (alive[i]) begin
               if (a < 0 || nwt[i] < nwt[a]) begin
                  b = a;
                  a = i;
               end else if (b < 0 || nwt[i] < nwt[b]) begin
                  b = i;
               end
            end
         end
         for (int c = 0; c < 8; c++) begin
            if (grp[c] == a || grp[c] == b) begin
               if (grp[c] == b) cd[c] = cd[c] + (1 << ln[c]);
               ln[c]  = ln[c] + 1;
               grp[c] = 8 + r;
            end
         end
         nwt[8+r]   = (nwt[a] + nwt[b] > 31) ? 31 : nwt[a] + nwt[b];
         alive[a]   = 1'b0;
         alive[b]   = 1'b0;
         alive[8+r] = 1'b1;
      end
      tot = 0;
      for (int c = 0; c < 8; c++) tot = tot + int'(wbuf[c]) * ln[c];
      for (int j = 0; j < 8; j++) begin
         e.cyc = t + 8 + j;
         e.ch  = j;
         e.ln  = ln[j];
         e.cd  = cd[j];
         e.tot = (j == 7) ? tot : 0;
         expq.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (bus.out_valid) begin
            if (expq.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               e = expq.pop_front();
               chk("beat_cycle", cyc, e.cyc);
               chk("out_char", int'(bus.out_char), e.ch);
               chk("out_len", int'(bus.out_len), e.ln);
               chk("out_code", int'(bus.out_code), e.cd);
`ifdef HUFF_TOTAL_BITS_EN
               chk("total_bits", int'(bus.total_bits), e.tot);
`endif
            end
         end else begin
            chk("idle_outputs_zero",
                int'(bus.out_char) + int'(bus.out_len) + int'(bus.out_code), 0);
`ifdef HUFF_TOTAL_BITS_EN
            chk("idle_total_zero", int'(bus.total_bits), 0);
`endif
         end
      end
   end

   task automatic run_job(input int nw, input bit hold, input bit push);
      for (int k = 0; k < nw; k++) begin
         @(posedge clk); #1;
         bus.in_valid  = 1'b1;
         bus.in_weight = wbuf[k];
         if (k == 0) begin
            #1;
            chk("busy_rise", int'(bus.busy), 1);
         end
         if (k == 7) last_t = cyc;
      end
      if (push && nw == 8) model_push(last_t);
      if (hold) begin
         repeat (15) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'b1;
            bus.in_weight = 5'($urandom_range(0, 31));
         end
      end else begin
         @(posedge clk); #1;
         bus.in_valid  = 1'b0;
         bus.in_weight = '0;
         if (nw < 8) begin
            chk("abort_busy_held", int'(bus.busy), 1);
            @(posedge clk); #1;
            chk("abort_busy_fall", int'(bus.busy), 0);
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("busy_fall_cycle", cyc, last_t + 16);
   endtask

   task automatic rand_wbuf();
      for (int k = 0; k < 8; k++)
         wbuf[k] = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
   endtask

   initial begin
      #(100000 * 10);
      $display("FAIL watchdog: simulation time limit reached, %0d expected beats pending", expq.size());
      $fatal(1);
   end

   initial begin
      int n;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_weight = '0;
      #2;
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_out_len", int'(bus.out_len), 0);
      chk("reset_out_code", int'(bus.out_code), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int k = 0; k < 8; k++) wbuf[k] = 5'd1;
      run_job(8, 1'b0, 1'b1);
      wait_idle();

      wbuf[0] = 5'd16;
      for (int k = 1; k < 8; k++) wbuf[k] = 5'd1;
      run_job(8, 1'b0, 1'b1);
      wait_idle();

      for (int k = 0; k < 8; k++) wbuf[k] = 5'd31;
      run_job(8, 1'b0, 1'b1);
      wait_idle();

      for (int k = 0; k < 8; k++) wbuf[k] = 5'd0;
      wbuf[2] = 5'd3;
      wbuf[4] = 5'd5;
      wbuf[7] = 5'd2;
      run_job(8, 1'b0, 1'b1);
      wait_idle();

      rand_wbuf();
      run_job(5, 1'b0, 1'b0);
      rand_wbuf();
      run_job(8, 1'b0, 1'b1);
      wait_idle();

      rand_wbuf();
      run_job(8, 1'b0, 1'b0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      chk("midjob_reset_busy", int'(bus.busy), 0);
      chk("midjob_reset_out_valid", int'(bus.out_valid), 0);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      rand_wbuf();
      run_job(8, 1'b0, 1'b1);
      wait_idle();

      rand_wbuf();
      run_job(8, 1'b1, 1'b1);
      rand_wbuf();
      run_job(8, 1'b0, 1'b1);
      wait_idle();

      for (int j = 0; j < 20; j++) begin
         rand_wbuf();
         run_job(8, 1'b0, 1'b1);
         wait_idle();
      end

      n = 0;
      while (expq.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", expq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/huff_tree_ctrl.md
Name: huff_tree_ctrl

Overview:
- Sequences an internal SORT_IP (IP_WIDTH=8) to build a Huffman code for 8 characters.
- Loads 8 weights serially, performs 7 merge rounds (one per cycle), then streams each character's code length and code.
- Sits between the serial input interface and the encoder/output stage of the Huffman top.

Parameters:
- NCHAR, 8, number of leaf characters; only 8 is supported.
- WW, 5, weight width; matches SORT_IP weight lanes.
- CW, 7, maximum code length in bits (NCHAR-1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  weight strobe; 8 contiguous cycles per job
- in_weight  input  5  weight of character k on the k-th in_valid cycle (k=0..7)
- busy  output  1  high from the first in_valid cycle until the last out_valid cycle
- out_valid  output  1  high for 8 consecutive cycles per job
- out_char  output  3  character index for the current output beat (0..7 ascending)
- out_len  output  3  code length 1..7; encoding 0 is not produced
- out_code  output  7  code, LSB-aligned; bit out_len-1 is the root-side bit

Behaviour:
- Reset: all outputs 0; FSM=IDLE; node tables cleared.
- FSM: IDLE -> LOAD -> MERGE -> OUT -> IDLE.
- IDLE:
  - in_valid=1 stores weight[0] and moves to LOAD with count=1.
  - busy rises in the same cycle as the first in_valid.
- LOAD:
  - Each in_valid stores weight[count]; after the 8th, moves to MERGE.
  - in_valid=0 before 8 weights: abort to IDLE, discard data, busy=0 next cycle.
- Node table: 15 slots (IDs 0..14), each holding a 5-bit weight, an active flag and an 8-bit leaf mask.
  - Leaves 0..7 start active with mask=1<<i.
  - Unused SORT_IP lanes are fed weight=31, index=15.
- MERGE round r (r=0..6), one cycle each:
  - SORT_IP sorts ascending by weight; ties resolve to the lower index first.
  - Sorted lane0 = node A, assigned bit 0; lane1 = node B, assigned bit 1.
  - For every leaf c in mask(A)|mask(B): code[c] |= bit<<len[c]; len[c]++.
  - New node ID 8+r: weight = min(wA+wB, 31) (saturating), mask = mask(A)|mask(B).
  - A and B become inactive.
  - After round 6, moves to OUT.
- Latency: last LOAD cycle = t; MERGE occupies t+1..t+7; out_valid spans t+8..t+15.
- OUT:
  - Beat j presents out_char=j, out_len=len[j], out_code=code[j].
  - Bits above out_len are 0.
  - After beat 7: out_valid=0 and busy=0 in the next cycle; outputs return to 0.
- in_valid while in MERGE or OUT is ignored. A new job may start in the cycle after busy falls.
- Weight 0 is legal and follows the same tie rules.
- Asynchronous reset mid-job: immediate return to IDLE, outputs 0, no partial output.

Optional Feature:
- Macro HUFF_TOTAL_BITS_EN.
- Defined:
  - Adds output total_bits [10:0] = sum over characters of in_weight*len, using original unsaturated weights.
  - Valid only on beat 7 of out_valid; 0 otherwise and at reset.
- Undefined: port and accumulator are absent; all other behaviour is identical.

Test Plan:
- All 8 weights=1 -> every out_len=3; codes c0..c7 = 000,001,010,011,100,101,110,111; out_valid 8 cycles after the last in_valid.
- Weights c0..c7 = 16,1,1,1,1,1,1,1 -> len 1,4,4,4,4,4,4,3; codes 1,0010,0011,0100,0101,0110,0111,000; total_bits=43 (with HUFF_TOTAL_BITS_EN).
- All weights=31 (saturation) -> merged weights stay 31; lengths and codes identical to the all-1 case.
- in_valid drops after 5 weights -> busy=0 next cycle, no out_valid; a following full 8-weight job completes normally.
- rst_n pulsed low during MERGE round 3 -> outputs 0 immediately; no out_valid until a new full load.
- in_valid held high during MERGE/OUT -> ignored; output identical to the undisturbed run; a back-to-back job started the cycle after busy falls is accepted.
